// File: rtl/inst_buffer_pkg.sv
`default_nettype none
// ============================================================================
// inst_buffer_pkg : decoded-instruction types shared by decode, the
//                   instruction buffer and dispatch
// Revision        : 1.0
// ============================================================================
package inst_buffer_pkg;

  localparam int SS_N       = 4;
  localparam int LANE_W     = (SS_N > 1) ? $clog2(SS_N) : 1;
  localparam int IBUF_DEPTH = 16;
  localparam int IBUF_IDX   = $clog2(IBUF_DEPTH);

  typedef enum logic [1:0] {
    OPA_IS_RS1  = 2'd0,
    OPA_IS_NPC  = 2'd1,
    OPA_IS_PC   = 2'd2,
    OPA_IS_ZERO = 2'd3
  } alu_opa_select_e;

  typedef enum logic [1:0] {
    OPB_IS_RS2   = 2'd0,
    OPB_IS_I_IMM = 2'd1,
    OPB_IS_S_IMM = 2'd2,
    OPB_IS_U_IMM = 2'd3
  } alu_opb_select_e;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_MUL    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JUMP   = 3'd5,
    OP_SYS    = 3'd6
  } op_type_e;

  // One lane of a decoded bundle; this is what each buffer entry stores.
  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [4:0]      rd_idx;
    logic            uses_rd;
    alu_opa_select_e opa_select;
    alu_opb_select_e opb_select;
    op_type_e        op_type;
    logic            rs2_immediate;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            halt;
  } DISP_INST;

  typedef struct packed {
    logic [SS_N-1:0][31:0]     pc;
    logic [SS_N-1:0][31:0]     inst;
    logic [SS_N-1:0][4:0]      rs1_idx;
    logic [SS_N-1:0][4:0]      rs2_idx;
    logic [SS_N-1:0][4:0]      rd_idx;
    logic [SS_N-1:0]           uses_rd;
    alu_opa_select_e [SS_N-1:0] opa_select;
    alu_opb_select_e [SS_N-1:0] opb_select;
    op_type_e [SS_N-1:0]       op_type;
    logic [SS_N-1:0]           rs2_immediate;
    logic [SS_N-1:0]           pred_taken;
    logic [SS_N-1:0][31:0]     pred_target;
    logic [SS_N-1:0]           halt;
  } FETCH_DISP_PACKET;

  function automatic DISP_INST pack_lane(input FETCH_DISP_PACKET pkt, input int lane);
    DISP_INST         r;
    logic [LANE_W-1:0] l;
    l               = LANE_W'(lane);
    r.pc            = pkt.pc[l];
    r.inst          = pkt.inst[l];
    r.rs1_idx       = pkt.rs1_idx[l];
    r.rs2_idx       = pkt.rs2_idx[l];
    r.rd_idx        = pkt.rd_idx[l];
    r.uses_rd       = pkt.uses_rd[l];
    r.opa_select    = pkt.opa_select[l];
    r.opb_select    = pkt.opb_select[l];
    r.op_type       = pkt.op_type[l];
    r.rs2_immediate = pkt.rs2_immediate[l];
    r.pred_taken    = pkt.pred_taken[l];
    r.pred_target   = pkt.pred_target[l];
    r.halt          = pkt.halt[l];
    return r;
  endfunction

  function automatic FETCH_DISP_PACKET unpack_lane(input FETCH_DISP_PACKET pkt,
                                                   input int lane,
                                                   input DISP_INST d);
    FETCH_DISP_PACKET  r;
    logic [LANE_W-1:0] l;
    r                  = pkt;
    l                  = LANE_W'(lane);
    r.pc[l]            = d.pc;
    r.inst[l]          = d.inst;
    r.rs1_idx[l]       = d.rs1_idx;
    r.rs2_idx[l]       = d.rs2_idx;
    r.rd_idx[l]        = d.rd_idx;
    r.uses_rd[l]       = d.uses_rd;
    r.opa_select[l]    = d.opa_select;
    r.opb_select[l]    = d.opb_select;
    r.op_type[l]       = d.op_type;
    r.rs2_immediate[l] = d.rs2_immediate;
    r.pred_taken[l]    = d.pred_taken;
    r.pred_target[l]   = d.pred_target;
    r.halt[l]          = d.halt;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
// inst_buffer : in-order circular queue of decoded instructions feeding dispatch
// Revision    : 1.0
// ============================================================================
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,  // power of two, at least 2*N
  parameter int N     = SS_N         // must match the lane count of FETCH_DISP_PACKET
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  FETCH_DISP_PACKET             in_packet,
  input  logic [N-1:0]                 in_valid,
  output logic                         in_ready,
  output FETCH_DISP_PACKET             disp_packet,
  output logic [N-1:0]                 disp_valid,
  input  logic [$clog2(N+1)-1:0]       dispatch_count,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W-1:0] head_next;
  logic [IDX_W-1:0] tail_next;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] occupancy_next;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] enq_k;
  logic [CNT_W-1:0] deq_req;
  logic [CNT_W-1:0] deq_d;
  logic             enq_fire;
  DISP_INST         rd_data [DEPTH];

  assign count      = occupancy;
  assign free_slots = CNT_W'(DEPTH) - occupancy;

  // Ready looks only at registered occupancy (and flush) so dispatch never
  // forms a combinational loop through this block.
  assign in_ready = (free_slots >= CNT_W'(N)) && !flush;
  assign enq_fire = in_ready && !flush;
  assign enq_k    = CNT_W'($countones(in_valid));
  assign deq_req  = CNT_W'(dispatch_count);
  assign deq_d    = (deq_req > occupancy) ? occupancy : deq_req;

  always_comb begin
    head_next      = head + IDX_W'(deq_d);
    tail_next      = tail + (enq_fire ? IDX_W'(enq_k) : '0);
    occupancy_next = occupancy + (enq_fire ? enq_k : '0) - deq_d;
    if (flush) begin
      head_next      = '0;
      tail_next      = '0;
      occupancy_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      head      <= head_next;
      tail      <= tail_next;
      occupancy <= occupancy_next;
    end
  end

  // Each entry picks its source lane from its distance past the tail.
  for (genvar e = 0; e < DEPTH; e++) begin : g_mem
    DISP_INST         entry;
    logic [IDX_W-1:0] offset;

    assign offset = IDX_W'(e) - tail;

    always_ff @(posedge clock) begin
      if (enq_fire && (CNT_W'(offset) < enq_k)) begin
        entry <= pack_lane(in_packet, int'(offset));
      end
    end

    assign rd_data[e] = entry;
  end

  always_comb begin
    disp_packet = '0;
    disp_valid  = '0;
    for (int i = 0; i < N; i++) begin
      if (CNT_W'(i) < occupancy) begin
        disp_valid[i] = 1'b1;
        disp_packet   = unpack_lane(disp_packet, i, rd_data[IDX_W'(head + IDX_W'(i))]);
      end
    end
  end

  logic [N-1:0] valid_plus1;
  assign valid_plus1 = in_valid + N'(1);

  a_in_valid_prefix: assert property (
    @(posedge clock) disable iff (!reset) ((in_valid & valid_plus1) == '0));

  a_dispatch_bound: assert property (
    @(posedge clock) disable iff (!reset) (flush || (deq_req <= occupancy)));

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// ============================================================================
// tb_inst_buffer : directed stimulus with a cycle-tagged scoreboard for inst_buffer
// Revision       : 1.0
// ============================================================================
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  FETCH_DISP_PACKET in_packet;
  FETCH_DISP_PACKET disp_packet;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     disp_valid;
  logic             in_ready;
  logic [2:0]       dispatch_count;
  logic [4:0]       count;

  inst_buffer #(.DEPTH(DEPTH), .N(N)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .in_packet      (in_packet),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .disp_packet    (disp_packet),
    .disp_valid     (disp_valid),
    .dispatch_count (dispatch_count),
    .count          (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int                cyc;
    logic [4:0]        cnt;
    logic [3:0]        vld;
    logic              rdy;
    logic [3:0][31:0]  pc;
  } exp_t;

  exp_t  expq[$];
  string nameq[$];
  int    cyc         = 0;
  int    vectors     = 0;
  int    miscompares = 0;

  function automatic logic [31:0] mkinst(input logic [31:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  // Monitor: at each falling edge, score every expectation tagged for this cycle.
  exp_t             me;
  string            mn;
  logic [3:0][31:0] mi;
  initial forever begin
    @(negedge clock);
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      me = expq.pop_front();
      mn = nameq.pop_front();
      for (int i = 0; i < N; i++) mi[i] = me.vld[i] ? mkinst(me.pc[i]) : 32'h0;
      vectors = vectors + 1;
      if (me.cyc != cyc) begin
        miscompares = miscompares + 1;
        $display("FAIL %s: sampled in cycle %0d, required cycle %0d", mn, cyc, me.cyc);
      end else if (count !== me.cnt || disp_valid !== me.vld || in_ready !== me.rdy ||
                   disp_packet.pc !== me.pc || disp_packet.inst !== mi) begin
        miscompares = miscompares + 1;
        $display("FAIL %s cyc=%0d: got count=%0d valid=%b ready=%b pc=%h inst=%h, want count=%0d valid=%b ready=%b pc=%h inst=%h",
                 mn, cyc, count, disp_valid, in_ready, disp_packet.pc, disp_packet.inst,
                 me.cnt, me.vld, me.rdy, me.pc, mi);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Lanes at or beyond k carry junk that must never reach the buffer.
  task automatic drv(input bit fl, input int k, input logic [31:0] pc0, input int dc);
    flush          = fl;
    dispatch_count = 3'(dc);
    in_valid       = 4'((1 << k) - 1);
    in_packet      = '0;
    for (int i = 0; i < N; i++) begin
      if (i < k) begin
        in_packet.pc[i]   = pc0 + 32'(4 * i);
        in_packet.inst[i] = mkinst(pc0 + 32'(4 * i));
      end else begin
        in_packet.pc[i]   = 32'hDEAD_0000 + 32'(i);
        in_packet.inst[i] = 32'hFFFF_FFFF;
      end
    end
  endtask

  task automatic chk(input string nm, input int c, input logic [3:0] v, input logic r,
                     input logic [31:0] p0, input logic [31:0] p1,
                     input logic [31:0] p2, input logic [31:0] p3);
    exp_t e;
    e.cyc   = cyc;
    e.cnt   = 5'(c);
    e.vld   = v;
    e.rdy   = r;
    e.pc[0] = p0;
    e.pc[1] = p1;
    e.pc[2] = p2;
    e.pc[3] = p3;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  // The check describes what is visible this cycle; the drive takes effect at the next edge.
  task automatic step(input bit fl, input int k, input logic [31:0] pc0, input int dc,
                      input string nm, input int c, input logic [3:0] v, input logic r,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic [31:0] p2, input logic [31:0] p3);
    tick();
    drv(fl, k, pc0, dc);
    chk(nm, c, v, r, p0, p1, p2, p3);
  endtask

  initial begin
    drv(0, 0, 32'h0, 0);
    reset = 1'b0;
    tick();
    chk("reset_state", 0, 4'b0000, 1'b1, 0, 0, 0, 0);
    reset = 1'b1;

    // partial dequeue
    step(0, 4, 32'h100, 0, "empty",     0, 4'b0000, 1, 0, 0, 0, 0);
    step(0, 0, 32'h0,   2, "enq4",      4, 4'b1111, 1, 32'h100, 32'h104, 32'h108, 32'h10C);
    step(0, 0, 32'h0,   2, "deq2",      2, 4'b0011, 1, 32'h108, 32'h10C, 0, 0);
    // simultaneous enqueue and dequeue
    step(0, 4, 32'h200, 0, "drained",   0, 4'b0000, 1, 0, 0, 0, 0);
    step(0, 1, 32'h210, 0, "fill4",     4, 4'b1111, 1, 32'h200, 32'h204, 32'h208, 32'h20C);
    step(0, 3, 32'h300, 2, "fill5",     5, 4'b1111, 1, 32'h200, 32'h204, 32'h208, 32'h20C);
    // wrap-around of tail and head
    step(0, 4, 32'h400, 4, "enq_deq",   6, 4'b1111, 1, 32'h208, 32'h20C, 32'h210, 32'h300);
    step(0, 4, 32'h500, 4, "wrap_tail", 6, 4'b1111, 1, 32'h304, 32'h308, 32'h400, 32'h404);
    step(0, 0, 32'h0,   4, "wrap_head", 6, 4'b1111, 1, 32'h408, 32'h40C, 32'h500, 32'h504);
    step(0, 0, 32'h0,   2, "wrap_tail2",2, 4'b0011, 1, 32'h508, 32'h50C, 0, 0);
    // full buffer
    step(0, 4, 32'h600, 0, "empty2",    0, 4'b0000, 1, 0, 0, 0, 0);
    step(0, 4, 32'h610, 0, "full_4",    4, 4'b1111, 1, 32'h600, 32'h604, 32'h608, 32'h60C);
    step(0, 4, 32'h620, 0, "full_8",    8, 4'b1111, 1, 32'h600, 32'h604, 32'h608, 32'h60C);
    step(0, 4, 32'h630, 0, "full_12",  12, 4'b1111, 1, 32'h600, 32'h604, 32'h608, 32'h60C);
    step(0, 4, 32'h700, 1, "full_16",  16, 4'b1111, 0, 32'h600, 32'h604, 32'h608, 32'h60C);
    step(0, 4, 32'h700, 3, "full_15",  15, 4'b1111, 0, 32'h604, 32'h608, 32'h60C, 32'h610);
    step(0, 0, 32'h0,   4, "full_12b", 12, 4'b1111, 1, 32'h610, 32'h614, 32'h618, 32'h61C);
    // flush priority
    step(0, 0, 32'h0,   1, "pre_fl8",   8, 4'b1111, 1, 32'h620, 32'h624, 32'h628, 32'h62C);
    step(1, 4, 32'h800, 4, "flush_rdy", 7, 4'b1111, 0, 32'h624, 32'h628, 32'h62C, 32'h630);
    step(0, 4, 32'h900, 0, "flushed",   0, 4'b0000, 1, 0, 0, 0, 0);
    step(0, 1, 32'h910, 0, "post_fl",   4, 4'b1111, 1, 32'h900, 32'h904, 32'h908, 32'h90C);
    step(0, 4, 32'hA00, 2, "five",      5, 4'b1111, 1, 32'h900, 32'h904, 32'h908, 32'h90C);

    // asynchronous reset between edges, with traffic still being driven
    @(posedge clock);
    #2;
    reset = 1'b0;
    chk("async_reset", 0, 4'b0000, 1, 0, 0, 0, 0);
    step(0, 0, 32'h0, 0, "reset_hold", 0, 4'b0000, 1, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 4, 32'hB00, 0, "released",  0, 4'b0000, 1, 0, 0, 0, 0);
    step(0, 0, 32'h0,   0, "refill",    4, 4'b1111, 1, 32'hB00, 32'hB04, 32'hB08, 32'hB0C);

    repeat (3) @(posedge clock);
    if (expq.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: %0d expectations left unscored, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/inst_buffer.md
# inst_buffer

Circular FIFO of decoded instructions between decode and `stage_dispatch`. Accepts up to `N` decoded instructions per cycle and presents the oldest up to `N` as a `FETCH_DISP_PACKET` plus `fetch_valid` mask. Retires entries in order according to the dispatch stage's `dispatch_count`. Decouples decode bandwidth from rename/ROB/RS stalls and is cleared on branch-mispredict flush.

## Interface
- `DEPTH`, default 16: number of instruction entries. Must be a power of two and ≥ 2·`N`.
- `N`, default `` `N ``: superscalar width.
- `clock`, input, 1 bit: single clock; all state updates on the rising edge.
- `reset`, input, 1 bit: reset is asynchronous and active-low.
- `flush`, input, 1 bit: mispredict recovery; empties the buffer.
- `in_packet`, input, `FETCH_DISP_PACKET`: decoded bundle from decode.
- `in_valid`, input, `N` bits: lane valids. Must be a contiguous prefix from lane 0.
- `in_ready`, output, 1 bit: buffer can accept a full `N`-wide bundle this cycle.
- `disp_packet`, output, `FETCH_DISP_PACKET`: oldest entries. Lane 0 is the oldest.
- `disp_valid`, output, `N` bits: valid mask for `disp_packet`. Always a contiguous prefix.
- `dispatch_count`, input, `$clog2(N+1)` bits: number of `disp_packet` lanes consumed this cycle.
- `count`, output, `$clog2(DEPTH+1)` bits: number of occupied entries.

## Operation
- **State**
  - `head` and `tail`: `$clog2(DEPTH)` bits each; wrap by natural overflow.
  - `count` register.
  - `mem[DEPTH]` of `DISP_INST`. Storage is not reset.
- **Enqueue**
  - Fires when `in_ready && !flush`.
  - Let `k = $countones(in_valid)`.
  - Lane `i < k` is written to `mem[tail+i]`, then `tail += k`.
  - If `in_ready` is 0, the bundle is ignored; decode must hold it.
- **`in_ready`**
  - `in_ready = (DEPTH - count) >= N && !flush`.
  - Depends on registered state and `flush` only, never on `dispatch_count`. This avoids a combinational loop with dispatch.
- **Output**
  - `disp_valid[i] = (i < count)`.
  - `disp_packet` lane `i = mem[head+i]` when valid; `'0` otherwise.
  - No bypass from `in_packet`.
- **Dequeue**
  - `d = min(dispatch_count, count)`, then `head += d`.
  - `dispatch_count > count` is a protocol violation: flag it with an assertion and clamp.
- **Count update**
  - Simultaneous enqueue and dequeue: `count_next = count + k - d`.
  - Overflow is impossible because `in_ready` guarantees `N` free slots.
- **Flush**
  - Highest priority of any event.
  - Next edge: `head = tail = count = 0`.
  - The same-cycle enqueue is dropped and `dispatch_count` is ignored.
- **Reset** (asynchronous, while `reset` is 0):
  - `head = tail = count = 0`.
  - `disp_valid = 0`, `disp_packet = '0`, `in_ready = 1`.
  - Takes effect immediately, independent of `clock`, including mid-operation.
- **Non-contiguous `in_valid`**: protocol error, caught by an assertion. Only `$countones` lanes from lane 0 are written.

## Timing
- Enqueue-to-visible latency is 1 cycle: an instruction written at edge *t* appears on `disp_packet` after edge *t*.
- Dequeue takes effect at the edge; the remaining entries shift to lane 0 in the next cycle.
- Sustained throughput is `N` per cycle when dispatch consumes `N` every cycle.
- Outputs are combinational from registers only. There is no input-to-output path except `flush` → `in_ready`.

## Structure
- **Shared package (`sys_defs.svh`)**
  - `DISP_INST`: a single-lane slice of `FETCH_DISP_PACKET` (PC, inst, rs1/rs2/rd idx, uses_rd, opa/opb_select, op_type, rs2_immediate, pred_taken, pred_target, halt).
  - Functions `pack_lane(FETCH_DISP_PACKET, int) → DISP_INST` and `unpack_lane(...)`.
  - Define `IBUF_DEPTH` and `IBUF_IDX` there as well.
- **Sub-modules**: none needed. This is a single module with a pointer/count block and a storage array.

## Test plan
1. **Async reset mid-operation**: 5 entries queued, `reset` driven 0 between clock edges → `count = 0`, `disp_valid = 0`, `in_ready = 1` immediately, with no clock edge needed.
2. **Partial dequeue**: `N = 4`. Enqueue PCs 0x100, 0x104, 0x108, 0x10C → next cycle `disp_valid = 4'b1111` with PCs in order. Apply `dispatch_count = 2` → following cycle lanes 0–1 show 0x108 and 0x10C, `disp_valid = 4'b0011`.
3. **Full buffer**: `DEPTH = 16`. Four 4-wide bundles with `dispatch_count = 0` → `count = 16`, `in_ready = 0`. Dispatch 1 → `in_ready` stays 0. Dispatch 3 more → `count = 12`, `in_ready = 1`.
4. **Wrap-around**: push and pop until `tail` passes 15 → 0 → program order is preserved across the boundary, and `disp_packet` lane order stays correct while `head` straddles 15/0.
5. **Simultaneous enqueue and dequeue**: `count = 5`, enqueue 3 (`in_valid = 4'b0111`) and `dispatch_count = 2` in the same cycle → `count = 6`, and the oldest lane is the 3rd-oldest prior entry.
6. **Flush priority**: `count = 7`, with `flush = 1`, a 4-wide enqueue and `dispatch_count = 4` all in the same cycle → next cycle `count = 0`, `disp_valid = 0`, the enqueued bundle is absent, and `in_ready = 1`.
